// File: rtl/ps2_kbd_ctrl_if.sv
// rtl/ps2_kbd_ctrl_if.sv - receiver-side and key-event-side signal bundle for ps2_kbd_ctrl
interface ps2_kbd_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             rx_ready;
  logic [7:0]       rx_data;
  logic             rx_overflow;
  logic             nextdata_n;
  logic             key_valid;
  logic             key_ready;
  logic [7:0]       key_code;
  logic             key_ext;
  logic             key_release;
  logic [CNT_W-1:0] press_cnt;
  logic             err;
  logic             err_clr;

  // slave is the controller; master is the receiver/consumer environment
  modport slave (
    input  rx_ready, rx_data, rx_overflow, key_ready, err_clr,
    output nextdata_n, key_valid, key_code, key_ext, key_release, press_cnt, err
  );

  modport master (
    output rx_ready, rx_data, rx_overflow, key_ready, err_clr,
    input  nextdata_n, key_valid, key_code, key_ext, key_release, press_cnt, err
  );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// rtl/ps2_kbd_ctrl.sv - PS/2 scan-byte sequencer folding E0/F0 prefixes into key events
// Optional repeat-make suppression is built when TYPEMATIC_FILTER_EN is defined.
module ps2_kbd_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 20,
  parameter int CNT_W          = 8
) (
  input  logic          clk,
  input  logic          clrn,
  ps2_kbd_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_POP, S_DECODE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             nextdata_n_q, nextdata_n_d;
  logic             key_valid_q, key_valid_d;
  logic [7:0]       key_code_q, key_code_d;
  logic             key_ext_q, key_ext_d;
  logic             key_release_q, key_release_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic             err_q, err_d;
  logic             ext_q, ext_d;
  logic             brk_q, brk_d;
  logic [TO_W-1:0]  to_q, to_d;
`ifdef TYPEMATIC_FILTER_EN
  logic             held_q, held_d;
  logic [8:0]       held_key_q, held_key_d;
`endif

  logic slot_busy;
  logic err_set;
  logic emit;

  always_comb begin
    state_d       = state_q;
    byte_d        = byte_q;
    nextdata_n_d  = nextdata_n_q;
    key_valid_d   = key_valid_q;
    key_code_d    = key_code_q;
    key_ext_d     = key_ext_q;
    key_release_d = key_release_q;
    press_cnt_d   = press_cnt_q;
    err_d         = err_q;
    ext_d         = ext_q;
    brk_d         = brk_q;
    to_d          = to_q;
`ifdef TYPEMATIC_FILTER_EN
    held_d        = held_q;
    held_key_d    = held_key_q;
`endif
    slot_busy     = key_valid_q & ~bus.key_ready;
    err_set       = bus.rx_overflow;
    emit          = 1'b0;

    if (key_valid_q && bus.key_ready) begin
      key_valid_d = 1'b0;
      if (!key_release_q) press_cnt_d = press_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.rx_ready && !slot_busy) begin
          byte_d       = bus.rx_data;
          nextdata_n_d = 1'b0;
          state_d      = S_POP;
          to_d         = '0;
        end else if (!(ext_q || brk_q)) begin
          to_d = '0;
        end else if (!bus.rx_ready) begin
          // A lone prefix whose follow-up byte never arrives is abandoned.
          if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            to_d    = '0;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
            err_set = 1'b1;
          end else begin
            to_d = to_q + TO_W'(1);
          end
        end
      end
      S_POP: begin
        nextdata_n_d = 1'b1;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_IDLE;
        case (byte_q)
          8'hE0: ext_d = 1'b1;
          8'hF0: brk_d = 1'b1;
          8'h00, 8'hFF: begin
            err_set = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
          end
          default: begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            emit  = 1'b1;
`ifdef TYPEMATIC_FILTER_EN
            if (!brk_q && held_q && held_key_q == {ext_q, byte_q}) begin
              emit = 1'b0;
            end else if (!brk_q) begin
              held_d     = 1'b1;
              held_key_d = {ext_q, byte_q};
            end else if (held_key_q == {ext_q, byte_q}) begin
              held_d = 1'b0;
            end
`endif
          end
        endcase
        if (emit) begin
          key_valid_d   = 1'b1;
          key_code_d    = byte_q;
          key_ext_d     = ext_q;
          key_release_d = brk_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.err_clr) err_d = 1'b0;
    if (err_set)     err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q       <= S_IDLE;
      byte_q        <= '0;
      nextdata_n_q  <= 1'b1;
      key_valid_q   <= 1'b0;
      key_code_q    <= '0;
      key_ext_q     <= 1'b0;
      key_release_q <= 1'b0;
      press_cnt_q   <= '0;
      err_q         <= 1'b0;
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      to_q          <= '0;
`ifdef TYPEMATIC_FILTER_EN
      held_q        <= 1'b0;
      held_key_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      byte_q        <= byte_d;
      nextdata_n_q  <= nextdata_n_d;
      key_valid_q   <= key_valid_d;
      key_code_q    <= key_code_d;
      key_ext_q     <= key_ext_d;
      key_release_q <= key_release_d;
      press_cnt_q   <= press_cnt_d;
      err_q         <= err_d;
      ext_q         <= ext_d;
      brk_q         <= brk_d;
      to_q          <= to_d;
`ifdef TYPEMATIC_FILTER_EN
      held_q        <= held_d;
      held_key_q    <= held_key_d;
`endif
    end
  end

  assign bus.nextdata_n  = nextdata_n_q;
  assign bus.key_valid   = key_valid_q;
  assign bus.key_code    = key_code_q;
  assign bus.key_ext     = key_ext_q;
  assign bus.key_release = key_release_q;
  assign bus.press_cnt   = press_cnt_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb/tb_ps2_kbd_ctrl.sv - scoreboard bench for ps2_kbd_ctrl with a queued receiver model
module tb_ps2_kbd_ctrl;

  logic clk  = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  ps2_kbd_ctrl_if #(.CNT_W(8)) ifc ();

  ps2_kbd_ctrl #(
    .TIMEOUT_CYCLES(16),
    .TO_W          (5),
    .CNT_W         (8)
  ) dut (
    .clk (clk),
    .clrn(clrn),
    .bus (ifc.slave)
  );

  int tests = 0;
  int fails = 0;
  int pops  = 0;
  int cyc   = 0;
  int last_pop = 0;
  logic prev_valid = 1'b0;

  logic [7:0] rxq[$];
  logic [9:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] b);
    rxq.push_back(b);
  endtask

  task automatic expect_ev(input logic e, input logic r, input logic [7:0] c);
    exp_q.push_back({e, r, c});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || rxq.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 400) begin
      fails++;
      $display("FAIL %s_drain: got %0d events pending expected 0", name, exp_q.size());
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_err_clr();
    ifc.err_clr = 1'b1;
    @(negedge clk);
    ifc.err_clr = 1'b0;
    @(negedge clk);
  endtask

  // Receiver FIFO model: head byte leaves at the end of each nextdata_n low cycle.
  always @(negedge clk) begin
    if (clrn && !ifc.nextdata_n) begin
      if (rxq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pop_empty: got pop expected none");
      end else begin
        void'(rxq.pop_front());
        pops++;
      end
    end
    ifc.rx_ready = (rxq.size() != 0);
    ifc.rx_data  = (rxq.size() != 0) ? rxq[0] : 8'h00;
  end

  // Monitor: compares every accepted event against the scoreboard and checks pop-to-valid latency.
  always @(negedge clk) begin
    logic [9:0] e;
    cyc++;
    if (!clrn) begin
      prev_valid = 1'b0;
    end else begin
      if (!ifc.nextdata_n) last_pop = cyc;
      if (ifc.key_valid && !prev_valid) check("latency", cyc - last_pop, 2);
      if (ifc.key_valid && ifc.key_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_event: got %0h expected none",
                   {ifc.key_ext, ifc.key_release, ifc.key_code});
        end else begin
          e = exp_q.pop_front();
          check("event", {22'd0, ifc.key_ext, ifc.key_release, ifc.key_code}, {22'd0, e});
        end
      end
      prev_valid = ifc.key_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.key_ready   = 1'b1;
    ifc.err_clr     = 1'b0;
    ifc.rx_overflow = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_nextdata_n", ifc.nextdata_n, 1);
    check("rst_key_valid", ifc.key_valid, 0);
    check("rst_key_code", ifc.key_code, 0);
    check("rst_key_ext", ifc.key_ext, 0);
    check("rst_key_release", ifc.key_release, 0);
    check("rst_press_cnt", ifc.press_cnt, 0);
    check("rst_err", ifc.err, 0);
    clrn = 1'b1;

    // make then break of 1C
    pops = 0;
    push(8'h1C); push(8'hF0); push(8'h1C);
    expect_ev(0, 0, 8'h1C); expect_ev(0, 1, 8'h1C);
    drain("t1");
    check("t1_press_cnt", ifc.press_cnt, 1);
    check("t1_pops", pops, 3);

    // extended break, both prefix orders, repeated prefix
    pops = 0;
    push(8'hE0); push(8'hF0); push(8'h75);
    expect_ev(1, 1, 8'h75);
    drain("t2a");
    push(8'hF0); push(8'hE0); push(8'hF0); push(8'h75);
    expect_ev(1, 1, 8'h75);
    drain("t2b");
    push(8'hE0); push(8'hE0); push(8'h5A);
    expect_ev(1, 0, 8'h5A);
    drain("t2c");
    check("t2_pops", pops, 10);
    check("t2_press_cnt", ifc.press_cnt, 2);

    // backpressure holds the first event and blocks further pops
    ifc.key_ready = 1'b0;
    pops = 0;
    push(8'h1C); push(8'h32);
    expect_ev(0, 0, 8'h1C); expect_ev(0, 0, 8'h32);
    repeat (20) @(negedge clk);
    check("t3_hold_valid", ifc.key_valid, 1);
    check("t3_hold_code", ifc.key_code, 8'h1C);
    check("t3_hold_pops", pops, 1);
    check("t3_rx_left", rxq.size(), 1);
    check("t3_hold_press", ifc.press_cnt, 2);
    ifc.key_ready = 1'b1;
    drain("t3");
    check("t3_press_cnt", ifc.press_cnt, 4);
    check("t3_pops", pops, 2);

    // prefix timeout, bad bytes, overflow, err_clr priority
    check("t4_err_pre", ifc.err, 0);
    push(8'hE0);
    repeat (10) @(negedge clk);
    check("t4_no_early_timeout", ifc.err, 0);
    repeat (15) @(negedge clk);
    check("t4_timeout_err", ifc.err, 1);
    check("t4_timeout_no_event", ifc.key_valid, 0);
    push(8'h1C);
    expect_ev(0, 0, 8'h1C);
    drain("t4");
    pulse_err_clr();
    check("t4_err_clr", ifc.err, 0);
    push(8'h00);
    repeat (10) @(negedge clk);
    check("t4_zero_err", ifc.err, 1);
    check("t4_zero_no_event", ifc.key_valid, 0);
    pulse_err_clr();
    check("t4_err_clr2", ifc.err, 0);
    push(8'hE0); push(8'hFF); push(8'h2B);
    expect_ev(0, 0, 8'h2B);
    drain("t4ff");
    check("t4_ff_err", ifc.err, 1);
    pulse_err_clr();
    ifc.rx_overflow = 1'b1;
    @(negedge clk);
    ifc.rx_overflow = 1'b0;
    @(negedge clk);
    check("t4_ovf_err", ifc.err, 1);
    ifc.err_clr = 1'b1;
    ifc.rx_overflow = 1'b1;
    @(negedge clk);
    ifc.err_clr = 1'b0;
    ifc.rx_overflow = 1'b0;
    @(negedge clk);
    check("t4_new_err_wins", ifc.err, 1);
    pulse_err_clr();
    check("t4_err_clr3", ifc.err, 0);
    check("t4_press_cnt", ifc.press_cnt, 6);

    // reset while nextdata_n is low: the popped byte is lost
    push(8'h4D);
    begin
      int n = 0;
      while (n < 20) begin
        @(negedge clk);
        if (!ifc.nextdata_n) break;
        n++;
      end
      check("t6_pop_seen", (n < 20), 1);
    end
    #2 clrn = 1'b0;
    #1;
    check("t6_pop_rst_nextdata_n", ifc.nextdata_n, 1);
    check("t6_pop_rst_press", ifc.press_cnt, 0);
    @(negedge clk);
    clrn = 1'b1;

    // reset while an event is held: event lost, queued byte delivered afterwards
    ifc.key_ready = 1'b0;
    push(8'h1C); push(8'h32);
    repeat (12) @(negedge clk);
    check("t6_hold_valid", ifc.key_valid, 1);
    ifc.rx_overflow = 1'b1;
    @(negedge clk);
    ifc.rx_overflow = 1'b0;
    #2 clrn = 1'b0;
    #1;
    check("t6_rst_valid", ifc.key_valid, 0);
    check("t6_rst_code", ifc.key_code, 0);
    check("t6_rst_nextdata_n", ifc.nextdata_n, 1);
    check("t6_rst_err", ifc.err, 0);
    @(negedge clk);
    clrn = 1'b1;
    expect_ev(0, 0, 8'h32);
    ifc.key_ready = 1'b1;
    drain("t6");
    check("t6_press_cnt", ifc.press_cnt, 1);

    // typematic repeats
    @(negedge clk);
    clrn = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    pops = 0;
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C); push(8'h1C);
`ifdef TYPEMATIC_FILTER_EN
    expect_ev(0, 0, 8'h1C); expect_ev(0, 1, 8'h1C); expect_ev(0, 0, 8'h1C);
    drain("t5");
    check("t5_press_cnt", ifc.press_cnt, 2);
`else
    expect_ev(0, 0, 8'h1C); expect_ev(0, 0, 8'h1C); expect_ev(0, 0, 8'h1C);
    expect_ev(0, 1, 8'h1C); expect_ev(0, 0, 8'h1C);
    drain("t5");
    check("t5_press_cnt", ifc.press_cnt, 4);
`endif
    check("t5_pops", pops, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
